// File: rtl/uart_rx_engine.sv
// Oversampling UART receiver: rx synchroniser, baud tick divider and frame FSM.
// Define UART_RX_PARITY_EN to include the parity bit stage.
module uart_rx_engine #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic [15:0]           baudDivisor,
    input  logic [4:0]            overSampling,
    input  logic [3:0]            dataBits,
    input  logic [1:0]            stopBits,
    input  logic                  parityType,
    output logic [DATA_WIDTH-1:0] rxData,
    output logic                  rxValid,
    output logic                  parityError,
    output logic                  framingError,
    output logic                  busy
);
    localparam logic [4:0] DW5 = 5'(DATA_WIDTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s, rx_prev_q, fall;
    logic [15:0]            div_cnt_q;
    logic [4:0]             tick_cnt_q, os_q, os_in, tick_target;
    logic [3:0]             bit_cnt_q, nbits_q, nbits_in;
    logic                   stop2_q, frm_acc_q;
    logic                   tick, sample, last_data, last_stop;
    logic [DATA_WIDTH-1:0]  shift_q;
`ifdef UART_RX_PARITY_EN
    logic                   par_type_q, par_acc_q, par_bad_q;
`else
    logic                   unused_par_type;
    assign unused_par_type = parityType;
    assign parityError     = 1'b0;
`endif

    assign rx_s = sync_q[SYNC_STAGES-1];
    assign fall = rx_prev_q & ~rx_s;
    assign busy = (state_q != IDLE);

    // Illegal configuration values fall back to 8 data bits, X16, 1 stop bit.
    always_comb begin
        nbits_in = dataBits;
        if (dataBits < 4'd5 || {1'b0, dataBits} > DW5)
            nbits_in = 4'd8;
        os_in = (overSampling == 5'd13) ? 5'd13 : 5'd16;
    end

    assign tick        = (div_cnt_q == baudDivisor - 16'd1);
    assign tick_target = (state_q == START) ? (os_q >> 1) - 5'd1 : os_q - 5'd1;
    assign sample      = tick && (tick_cnt_q == tick_target);
    assign last_data   = (bit_cnt_q == nbits_q - 4'd1);
    assign last_stop   = !stop2_q || (bit_cnt_q == 4'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (fall) state_d = START;
            START:  if (sample) state_d = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (sample && last_data) state_d = PARITY;
            PARITY: if (sample) state_d = STOP;
`else
            DATA:   if (sample && last_data) state_d = STOP;
`endif
            STOP:   if (sample && last_stop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q       <= '1;
            rx_prev_q    <= 1'b1;
            div_cnt_q    <= '0;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            os_q         <= 5'd16;
            nbits_q      <= 4'd8;
            stop2_q      <= 1'b0;
            frm_acc_q    <= 1'b0;
            shift_q      <= '0;
            rxData       <= '0;
            rxValid      <= 1'b0;
            framingError <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_type_q   <= 1'b0;
            par_acc_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            parityError  <= 1'b0;
`endif
        end else begin
            sync_q       <= SYNC_STAGES'({sync_q, rx});
            rx_prev_q    <= rx_s;
            rxValid      <= 1'b0;
            framingError <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityError  <= 1'b0;
`endif
            if (state_q == IDLE) begin
                div_cnt_q  <= '0;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
                if (fall) begin
                    os_q      <= os_in;
                    nbits_q   <= nbits_in;
                    stop2_q   <= (stopBits == 2'd2);
                    frm_acc_q <= 1'b0;
                    shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
                    par_type_q <= parityType;
                    par_acc_q  <= 1'b0;
                    par_bad_q  <= 1'b0;
`endif
                end
            end else begin
                div_cnt_q <= tick ? '0 : div_cnt_q + 16'd1;
                if (tick)
                    tick_cnt_q <= sample ? '0 : tick_cnt_q + 5'd1;
                if (sample) begin
                    case (state_q)
                        DATA: begin
                            shift_q   <= {rx_s, shift_q[DATA_WIDTH-1:1]};
                            bit_cnt_q <= last_data ? '0 : bit_cnt_q + 4'd1;
`ifdef UART_RX_PARITY_EN
                            par_acc_q <= par_acc_q ^ rx_s;
`endif
                        end
`ifdef UART_RX_PARITY_EN
                        PARITY: par_bad_q <= ((par_acc_q ^ rx_s) != par_type_q);
`endif
                        STOP: begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            frm_acc_q <= frm_acc_q | ~rx_s;
                            if (last_stop) begin
                                // Data sits in the top nbits of shift_q; right-align it.
                                rxData       <= shift_q >> (DW5 - {1'b0, nbits_q});
                                rxValid      <= 1'b1;
                                framingError <= frm_acc_q | ~rx_s;
`ifdef UART_RX_PARITY_EN
                                parityError  <= par_bad_q;
`endif
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed self-checking bench for uart_rx_engine; adapts framing to UART_RX_PARITY_EN.
module tb_uart_rx_engine;
    localparam int DW = 8;
    localparam int BD = 4;
`ifdef UART_RX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic [15:0]   baudDivisor;
    logic [4:0]    overSampling;
    logic [3:0]    dataBits;
    logic [1:0]    stopBits;
    logic          parityType;
    logic [DW-1:0] rxData;
    logic          rxValid, parityError, framingError, busy;

    uart_rx_engine #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .rx(rx), .baudDivisor(baudDivisor),
        .overSampling(overSampling), .dataBits(dataBits), .stopBits(stopBits),
        .parityType(parityType), .rxData(rxData), .rxValid(rxValid),
        .parityError(parityError), .framingError(framingError), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          pe;
        logic          fe;
    } rec_t;
    rec_t got[$];

    int tests_run = 0;
    int tests_failed = 0;

    always @(negedge clk)
        if (rxValid === 1'b1) got.push_back(rec_t'{rxData, parityError, framingError});

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int os);
        rx = b;
        clks(os * BD);
    endtask

    task automatic set_cfg(input logic [4:0] os, input logic [3:0] nb,
                           input logic [1:0] sb, input logic pt);
        overSampling = os; dataBits = nb; stopBits = sb; parityType = pt;
    endtask

    // perturb: scramble config inputs right after the start bit; the frame must be unaffected.
    task automatic send_frame(input logic [DW-1:0] d, input int nb, input logic par_bit,
                              input logic s1, input logic s2, input int nstop,
                              input int os, input bit perturb);
        drive_bit(1'b0, os);
        if (perturb) set_cfg(5'd13, 4'd5, 2'd2, ~parityType);
        for (int i = 0; i < nb; i++) drive_bit(d[i], os);
        if (HAS_PAR) drive_bit(par_bit, os);
        drive_bit(s1, os);
        if (nstop == 2) drive_bit(s2, os);
        rx = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; rx = 1'b1; baudDivisor = 16'(BD);
        set_cfg(5'd16, 4'd8, 2'd1, 1'b0);
        clks(5);
        @(negedge clk);
        tests_run++; if (rxValid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, expected 0", rxValid); end
        tests_run++; if (rxData !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h, expected 00", rxData); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        tests_run++; if (parityError !== 1'b0) begin tests_failed++; $display("FAIL reset_pe: got %b, expected 0", parityError); end
        tests_run++; if (framingError !== 1'b0) begin tests_failed++; $display("FAIL reset_fe: got %b, expected 0", framingError); end
        reset = 1'b0;
        clks(5);
    endtask

    task automatic test_basic;
        set_cfg(5'd16, 4'd8, 2'd1, 1'b0);
        got.delete();
        send_frame(8'hA5, 8, 1'b0, 1'b1, 1'b1, 1, 16, 1'b1);
        set_cfg(5'd16, 4'd8, 2'd1, 1'b0);
        clks(2 * 16 * BD);
        tests_run++; if (got.size() != 1) begin tests_failed++; $display("FAIL basic_count: got %0d, expected 1", got.size()); end
        if (got.size() > 0) begin
            tests_run++; if (got[0].data !== 8'hA5) begin tests_failed++; $display("FAIL basic_data: got %h, expected a5", got[0].data); end
            tests_run++; if (got[0].pe !== 1'b0) begin tests_failed++; $display("FAIL basic_pe: got %b, expected 0", got[0].pe); end
            tests_run++; if (got[0].fe !== 1'b0) begin tests_failed++; $display("FAIL basic_fe: got %b, expected 0", got[0].fe); end
        end
    endtask

    task automatic test_parity_error;
        set_cfg(5'd16, 4'd8, 2'd1, 1'b0);
        got.delete();
        send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1, 1, 16, 1'b0);
        clks(2 * 16 * BD);
        tests_run++; if (got.size() != 1) begin tests_failed++; $display("FAIL par_count: got %0d, expected 1", got.size()); end
        if (got.size() > 0) begin
            tests_run++; if (got[0].data !== 8'hA5) begin tests_failed++; $display("FAIL par_data: got %h, expected a5", got[0].data); end
            tests_run++; if (got[0].pe !== HAS_PAR) begin tests_failed++; $display("FAIL par_pe: got %b, expected %b", got[0].pe, HAS_PAR); end
            tests_run++; if (got[0].fe !== 1'b0) begin tests_failed++; $display("FAIL par_fe: got %b, expected 0", got[0].fe); end
        end
    endtask

    task automatic test_framing;
        set_cfg(5'd13, 4'd7, 2'd2, 1'b1);
        got.delete();
        send_frame(8'h55, 7, 1'b1, 1'b1, 1'b0, 2, 13, 1'b0);
        clks(2 * 13 * BD);
        tests_run++; if (got.size() != 1) begin tests_failed++; $display("FAIL frm_count: got %0d, expected 1", got.size()); end
        if (got.size() > 0) begin
            tests_run++; if (got[0].data !== 8'h55) begin tests_failed++; $display("FAIL frm_data: got %h, expected 55", got[0].data); end
            tests_run++; if (got[0].fe !== 1'b1) begin tests_failed++; $display("FAIL frm_fe: got %b, expected 1", got[0].fe); end
            tests_run++; if (got[0].pe !== 1'b0) begin tests_failed++; $display("FAIL frm_pe: got %b, expected 0", got[0].pe); end
        end
        tests_run++; if (framingError !== 1'b0) begin tests_failed++; $display("FAIL frm_fe_idle: got %b, expected 0", framingError); end
    endtask

    task automatic test_glitch;
        set_cfg(5'd16, 4'd8, 2'd1, 1'b0);
        got.delete();
        rx = 1'b0;
        clks(3 * BD);
        rx = 1'b1;
        clks(4);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL glitch_busy_hi: got %b, expected 1", busy); end
        clks(30);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy_lo: got %b, expected 0", busy); end
        clks(16 * BD);
        tests_run++; if (got.size() != 0) begin tests_failed++; $display("FAIL glitch_count: got %0d, expected 0", got.size()); end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] exp_d [3];
        exp_d[0] = 8'h1F; exp_d[1] = 8'h00; exp_d[2] = 8'h15;
        set_cfg(5'd16, 4'd5, 2'd1, 1'b0);
        got.delete();
        send_frame(8'h1F, 5, 1'b1, 1'b1, 1'b1, 1, 16, 1'b0);
        send_frame(8'h00, 5, 1'b0, 1'b1, 1'b1, 1, 16, 1'b0);
        send_frame(8'h15, 5, 1'b1, 1'b1, 1'b1, 1, 16, 1'b0);
        clks(2 * 16 * BD);
        tests_run++; if (got.size() != 3) begin tests_failed++; $display("FAIL b2b_count: got %0d, expected 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            tests_run++;
            if (got[i].data !== exp_d[i] || got[i].fe !== 1'b0 || got[i].pe !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_frame%0d: got %h pe=%b fe=%b, expected %h pe=0 fe=0",
                         i, got[i].data, got[i].pe, got[i].fe, exp_d[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        set_cfg(5'd16, 4'd8, 2'd1, 1'b0);
        got.delete();
        drive_bit(1'b0, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b0, 16);
        drive_bit(1'b1, 16);
        reset = 1'b1; rx = 1'b1;
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
        tests_run++; if (rxData !== 8'h00) begin tests_failed++; $display("FAIL rstmid_data: got %h, expected 00", rxData); end
        clks(4);
        reset = 1'b0;
        clks(16 * BD);
        tests_run++; if (got.size() != 0) begin tests_failed++; $display("FAIL rstmid_aborted: got %0d, expected 0", got.size()); end
        send_frame(8'h3C, 8, 1'b0, 1'b1, 1'b1, 1, 16, 1'b0);
        clks(2 * 16 * BD);
        tests_run++; if (got.size() != 1) begin tests_failed++; $display("FAIL rstmid_count: got %0d, expected 1", got.size()); end
        if (got.size() > 0) begin
            tests_run++; if (got[0].data !== 8'h3C) begin tests_failed++; $display("FAIL rstmid_data2: got %h, expected 3c", got[0].data); end
        end
    endtask

    task automatic test_break;
        set_cfg(5'd16, 4'd8, 2'd1, 1'b0);
        got.delete();
        rx = 1'b0;
        clks(20 * 16 * BD);
        rx = 1'b1;
        clks(3 * 16 * BD);
        tests_run++; if (got.size() != 1) begin tests_failed++; $display("FAIL break_count: got %0d, expected 1", got.size()); end
        if (got.size() > 0) begin
            tests_run++; if (got[0].data !== 8'h00) begin tests_failed++; $display("FAIL break_data: got %h, expected 00", got[0].data); end
            tests_run++; if (got[0].fe !== 1'b1) begin tests_failed++; $display("FAIL break_fe: got %b, expected 1", got[0].fe); end
            tests_run++; if (got[0].pe !== 1'b0) begin tests_failed++; $display("FAIL break_pe: got %b, expected 0", got[0].pe); end
        end
    endtask

    task automatic test_clamp;
        set_cfg(5'd0, 4'd15, 2'd3, 1'b0);
        got.delete();
        send_frame(8'hA5, 8, 1'b0, 1'b1, 1'b1, 1, 16, 1'b0);
        clks(2 * 16 * BD);
        tests_run++; if (got.size() != 1) begin tests_failed++; $display("FAIL clamp_count: got %0d, expected 1", got.size()); end
        if (got.size() > 0) begin
            tests_run++; if (got[0].data !== 8'hA5) begin tests_failed++; $display("FAIL clamp_data: got %h, expected a5", got[0].data); end
            tests_run++; if (got[0].fe !== 1'b0) begin tests_failed++; $display("FAIL clamp_fe: got %b, expected 0", got[0].fe); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_error();
        test_framing();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        test_break();
        test_clamp();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/uart_rx_engine.md
UART_RX_ENGINE -- requirements
Module: uart_rx_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the maximum data bits per character.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the number of input synchroniser flops on rx.
REQ-003 SHALL have port clk, input, 1, the single clock for all state.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port rx, input, 1, the serial line, idle high.
REQ-006 SHALL have port baudDivisor, input, 16, the clk cycles per oversample tick (legal 1..65535).
REQ-007 SHALL have port overSampling, input, 5, the ticks per bit (legal 16 or 13).
REQ-008 SHALL have port dataBits, input, 4, the character length (legal 5..DATA_WIDTH).
REQ-009 SHALL have port stopBits, input, 2, the stop-bit count (legal 1 or 2).
REQ-010 SHALL have port parityType, input, 1, where 0 = even and 1 = odd.
REQ-011 SHALL have port rxData, output, DATA_WIDTH, the received character, LSB first, unused upper bits 0.
REQ-012 SHALL have port rxValid, output, 1, a one-cycle pulse that qualifies rxData and the error flags.
REQ-013 SHALL have ports parityError and framingError, outputs, 1 each, valid only while rxValid=1 and otherwise 0.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 SHALL pass rx through SYNC_STAGES flops (reset value 1); all logic SHALL use the synchronised value.
REQ-016 SHALL generate a tick when divCnt == baudDivisor-1, then wrap divCnt to 0; divCnt SHALL clear on entry to START.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE->START SHALL occur on a synchronised 1->0 edge; a low level without an edge after reset SHALL NOT start a frame.
REQ-019 SHALL latch dataBits, stopBits, parityType and overSampling on IDLE->START; input changes mid-frame SHALL have no effect.
REQ-020 START SHALL sample after overSampling/2 ticks (8 or 6); sample=1 -> false start, return to IDLE with no rxValid; sample=0 -> DATA.
REQ-021 Every subsequent bit SHALL be sampled exactly overSampling ticks after the previous sample.
REQ-022 DATA SHALL shift in latched dataBits bits LSB first, then go to PARITY when parity is compiled in, else to STOP.
REQ-023 PARITY SHALL set parityError when the XOR of data and the parity bit is not equal to parityType.
REQ-024 STOP SHALL sample latched stopBits bits; any stop-bit sample of 0 SHALL set framingError.
REQ-025 After the last stop sample, rxValid SHALL pulse on the next clk with rxData and flags, and the FSM SHALL return to IDLE in the same cycle.
REQ-026 A new start edge SHALL be accepted on the first cycle in IDLE, so back-to-back frames without idle gap are received.
REQ-027 A break (line held at 0) SHALL yield one rxValid with rxData=0 and framingError=1, with no further frames until rx returns to 1 and falls again.
REQ-028 Illegal dataBits, stopBits or overSampling values SHALL clamp to 8, 1 and 16 respectively.

Reset
REQ-029 Asserting reset at any time, including mid-frame, SHALL force IDLE, divCnt=0, tick counter=0 and synchroniser=1s.
REQ-030 Asserting reset at any time SHALL force rxData=0, rxValid=0, parityError=0, framingError=0 and busy=0.
REQ-031 SHALL produce no rxValid from a frame interrupted by reset.

Configuration
REQ-032 Macro UART_RX_PARITY_EN defined: the PARITY state is included and parityError operates per REQ-023.
REQ-033 Macro UART_RX_PARITY_EN undefined: no PARITY state exists, DATA goes directly to STOP, parityType is ignored and parityError is tied to 0.

Verification
REQ-034 With parity compiled in, baudDivisor=4, X16, 8 bits, 1 stop, even parity, frame 0xA5 with parity bit 0 -> rxValid once, rxData=0xA5, both flags 0.
REQ-035 With the same settings and the parity bit flipped to 1 -> rxData=0xA5, parityError=1.
REQ-036 For a 7-bit odd-parity, 2-stop frame, X13, 0x55, second stop bit driven 0 -> rxData=0x55, framingError=1.
REQ-037 For a 3-tick low glitch on rx in IDLE at X16 -> no rxValid, busy returns to 0 after 8 ticks.
REQ-038 For 5-bit frames 0x1F, 0x00, 0x15 back-to-back at X16 -> three rxValid pulses with the correct data.
REQ-039 For reset asserted mid-DATA, then a clean 0x3C frame -> no rxValid for the aborted frame, then rxData=0x3C.
